// File: rtl/btn_scan_deb.sv
// btn_scan_deb: three independent button channels, each synchronized, debounced
// and expanded into press / auto-repeat pulses plus a debounced level.
module btn_scan_deb #(
  parameter logic [19:0] DEB_CLK_CNT   = 20'd50000,
  parameter logic [19:0] REP_DELAY_CNT = 20'd600000,
  parameter logic [19:0] REP_RATE_CNT  = 20'd200000,
  parameter logic        REP_EN        = 1'b1
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic [2:0] i_btn,
  output logic [2:0] o_press,
  output logic [2:0] o_level
);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD_DELAY, HELD_REPEAT, DEB_RELEASE} state_t;
  logic [2:0] meta_q, sync_q;
  always_ff @(posedge i_clk or posedge rst)
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_btn;
      sync_q <= meta_q;
    end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        press_q, press_d, level_q, level_d;
    logic        btn, zero;
    assign btn  = sync_q[c];
    assign zero = cnt_q == '0;
    always_ff @(posedge i_clk or posedge rst)
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d & ~press_q;
        level_q <= level_d;
      end
    // Input changes are tested before expiry so a release always wins over a pending pulse.
    always_comb begin
      state_d = state_q;
      cnt_d   = zero ? cnt_q : cnt_q - 20'd1;
      press_d = 1'b0;
      level_d = level_q;
      case (state_q)
        IDLE:
          if (btn) begin
            state_d = DEB_PRESS;
            cnt_d   = DEB_CLK_CNT;
          end
        DEB_PRESS:
          if (!btn) state_d = IDLE;
          else if (zero) begin
            state_d = HELD_DELAY;
            cnt_d   = REP_DELAY_CNT;
            press_d = 1'b1;
            level_d = 1'b1;
          end
        HELD_DELAY:
          if (!btn) begin
            state_d = DEB_RELEASE;
            cnt_d   = DEB_CLK_CNT;
          end else if (zero && REP_EN) begin
            state_d = HELD_REPEAT;
            cnt_d   = REP_RATE_CNT;
            press_d = 1'b1;
          end
        HELD_REPEAT:
          if (!btn) begin
            state_d = DEB_RELEASE;
            cnt_d   = DEB_CLK_CNT;
          end else if (zero) begin
            cnt_d   = REP_RATE_CNT;
            press_d = 1'b1;
          end
        DEB_RELEASE:
          if (btn) begin
            state_d = HELD_DELAY;
            cnt_d   = REP_DELAY_CNT;
          end else if (zero) begin
            state_d = IDLE;
            level_d = 1'b0;
          end
        default: state_d = IDLE;
      endcase
    end
    assign o_press[c] = press_q;
    assign o_level[c] = level_q;
  end
endmodule

// File: tb/tb_btn_scan_deb.sv
// tb_btn_scan_deb: scoreboard bench with per-edge expected outputs derived from the
// documented latencies, one instance with auto-repeat and one without.
module tb_btn_scan_deb;
  logic       clk, rst;
  logic [2:0] i_btn;
  logic [2:0] o_press, o_level, press_n, level_n;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int         e;
    logic [2:0] press;
    logic [2:0] level;
  } exp_t;
  exp_t exp_q[$];
  exp_t ex;

  btn_scan_deb #(.DEB_CLK_CNT(20'd4), .REP_DELAY_CNT(20'd10), .REP_RATE_CNT(20'd3), .REP_EN(1'b1)) dut (
    .i_clk(clk), .rst(rst), .i_btn(i_btn), .o_press(o_press), .o_level(o_level));
  btn_scan_deb #(.DEB_CLK_CNT(20'd4), .REP_DELAY_CNT(20'd10), .REP_RATE_CNT(20'd3), .REP_EN(1'b0)) dut_n (
    .i_clk(clk), .rst(rst), .i_btn(i_btn), .o_press(press_n), .o_level(level_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task settle;
    i_btn = 3'b000;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst = 1'b0;
    i_btn = 3'b000;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o_press !== 3'b000 || o_level !== 3'b000) begin
      errors++;
      $display("FAIL reset_init press=%b level=%b expected 000/000", o_press, o_level);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int e = 0; e < 8; e++)
      exp_q.push_back('{e, (e == 7) ? 3'b001 : 3'b000, (e >= 7) ? 3'b001 : 3'b000});
    for (int e = 0; e < 8; e++) begin
      i_btn = 3'b001;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (o_press !== ex.press || o_level !== ex.level) begin
        errors++;
        $display("FAIL reset_press edge %0d press=%b level=%b expected %b/%b", ex.e, o_press, o_level, ex.press, ex.level);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (o_press !== 3'b000 || o_level !== 3'b000 || press_n !== 3'b000 || level_n !== 3'b000) begin
      errors++;
      $display("FAIL reset_async press=%b level=%b expected 000/000", o_press, o_level);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_press !== 3'b000 || o_level !== 3'b000) begin
      errors++;
      $display("FAIL reset_held press=%b level=%b expected 000/000", o_press, o_level);
    end
    #3 rst = 1'b0;
    for (int e = 0; e < 10; e++)
      exp_q.push_back('{e, (e == 7) ? 3'b001 : 3'b000, (e >= 7) ? 3'b001 : 3'b000});
    for (int e = 0; e < 10; e++) begin
      i_btn = 3'b001;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (o_press !== ex.press || o_level !== ex.level) begin
        errors++;
        $display("FAIL reset_repress edge %0d press=%b level=%b expected %b/%b", ex.e, o_press, o_level, ex.press, ex.level);
      end
    end
  endtask

  task test_hold;
    for (int e = 0; e < 40; e++)
      exp_q.push_back('{e, (e inside {7, 18, 22, 26, 30}) ? 3'b001 : 3'b000,
                        (e >= 7 && e < 37) ? 3'b001 : 3'b000});
    for (int e = 0; e < 40; e++) begin
      i_btn = (e < 30) ? 3'b001 : 3'b000;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (o_press !== ex.press || o_level !== ex.level) begin
        errors++;
        $display("FAIL hold edge %0d press=%b level=%b expected %b/%b", ex.e, o_press, o_level, ex.press, ex.level);
      end
    end
  endtask

  task test_glitch;
    for (int e = 0; e < 20; e++) exp_q.push_back('{e, 3'b000, 3'b000});
    for (int e = 0; e < 20; e++) begin
      i_btn = (e < 3) ? 3'b010 : 3'b000;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (o_press !== ex.press || o_level !== ex.level) begin
        errors++;
        $display("FAIL glitch edge %0d press=%b level=%b expected %b/%b", ex.e, o_press, o_level, ex.press, ex.level);
      end
    end
  endtask

  task test_simultaneous;
    for (int e = 0; e < 40; e++)
      exp_q.push_back('{e, (e inside {7, 18, 22, 26, 30}) ? 3'b101 : 3'b000,
                        (e >= 7 && e < 37) ? 3'b101 : 3'b000});
    for (int e = 0; e < 40; e++) begin
      i_btn = (e < 30) ? 3'b101 : 3'b000;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (o_press !== ex.press || o_level !== ex.level) begin
        errors++;
        $display("FAIL simultaneous edge %0d press=%b level=%b expected %b/%b", ex.e, o_press, o_level, ex.press, ex.level);
      end
    end
  endtask

  task test_release_repress;
    for (int e = 0; e < 46; e++)
      exp_q.push_back('{e, (e inside {7, 18, 35, 39, 43}) ? 3'b001 : 3'b000,
                        (e >= 7) ? 3'b001 : 3'b000});
    for (int e = 0; e < 46; e++) begin
      i_btn = (e == 20 || e == 21) ? 3'b000 : 3'b001;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (o_press !== ex.press || o_level !== ex.level) begin
        errors++;
        $display("FAIL release_repress edge %0d press=%b level=%b expected %b/%b", ex.e, o_press, o_level, ex.press, ex.level);
      end
    end
  endtask

  task test_no_repeat;
    for (int e = 0; e < 50; e++)
      exp_q.push_back('{e, (e == 7) ? 3'b001 : 3'b000, (e >= 7 && e < 47) ? 3'b001 : 3'b000});
    for (int e = 0; e < 50; e++) begin
      i_btn = (e < 40) ? 3'b001 : 3'b000;
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checks++;
      if (press_n !== ex.press || level_n !== ex.level) begin
        errors++;
        $display("FAIL no_repeat edge %0d press=%b level=%b expected %b/%b", ex.e, press_n, level_n, ex.press, ex.level);
      end
    end
  endtask

  initial begin
    test_reset;
    settle;
    test_hold;
    settle;
    test_glitch;
    settle;
    test_simultaneous;
    settle;
    test_release_repress;
    settle;
    test_no_repeat;
    settle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_scan_deb.md
BTN_SCAN_DEB -- requirements
Module: btn_scan_deb

Interface
REQ-001 Parameter DEB_CLK_CNT, default 20'd50000, debounce reload value; a state change is accepted after DEB_CLK_CNT+1 stable cycles.
REQ-002 Parameter REP_DELAY_CNT, default 20'd600000, hold time reload before the first auto-repeat pulse.
REQ-003 Parameter REP_RATE_CNT, default 20'd200000, reload value between successive auto-repeat pulses.
REQ-004 Parameter REP_EN, default 1'b1; 1 enables auto-repeat, 0 gives one pulse per press.
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i_btn  input  3  raw asynchronous button levels, 1 = pressed.
REQ-008 o_press  output  3  per-button one-cycle pulse for an accepted press or an auto-repeat.
REQ-009 o_level  output  3  per-button debounced level, 1 = pressed.

Function
REQ-010 Each i_btn bit SHALL pass through a two-flop synchronizer before any other logic; the three channels SHALL be fully independent.
REQ-011 Each channel SHALL own a 20-bit down-counter and a state machine with states IDLE, DEB_PRESS, HELD_DELAY, HELD_REPEAT, DEB_RELEASE.
REQ-012 IDLE: synchronized input 1 -> DEB_PRESS, counter loaded with DEB_CLK_CNT; otherwise remain.
REQ-013 DEB_PRESS: input 0 -> IDLE with no output change; counter zero -> HELD_DELAY, counter loaded with REP_DELAY_CNT, o_press pulsed, o_level set; otherwise decrement.
REQ-014 HELD_DELAY: input 0 -> DEB_RELEASE, counter loaded with DEB_CLK_CNT; counter zero and REP_EN=1 -> HELD_REPEAT, counter loaded with REP_RATE_CNT, o_press pulsed; counter zero and REP_EN=0 -> remain, counter held at zero; otherwise decrement.
REQ-015 HELD_REPEAT: input 0 -> DEB_RELEASE, counter loaded with DEB_CLK_CNT; counter zero -> o_press pulsed, counter reloaded with REP_RATE_CNT; otherwise decrement.
REQ-016 DEB_RELEASE: input 1 -> HELD_DELAY, counter loaded with REP_DELAY_CNT, no pulse; counter zero -> IDLE, o_level cleared; otherwise decrement.
REQ-017 Input change SHALL take priority over counter expiry in the same cycle.
REQ-018 o_press and o_level SHALL be registered outputs; o_press SHALL never be high for two consecutive cycles.
REQ-019 Latency: with i_btn held, o_press SHALL rise on rising edge DEB_CLK_CNT+3 after the first edge that samples i_btn high; release SHALL clear o_level with the same latency.
REQ-020 The first repeat pulse SHALL follow the press pulse by REP_DELAY_CNT+1 cycles; subsequent pulses SHALL be spaced REP_RATE_CNT+1 cycles apart.
REQ-021 Bounce shorter than DEB_CLK_CNT+1 synchronized cycles SHALL produce no o_press pulse and no o_level change.
REQ-022 Counters SHALL never wrap below zero.

Reset
REQ-023 While rst=1, synchronizers, counters, o_press and o_level SHALL be 0, and all states SHALL be IDLE, taking effect without a clock edge.
REQ-024 After rst falls with a button already held, that button SHALL be treated as a new press, with latency per REQ-019.

Verification (DEB_CLK_CNT=4, REP_DELAY_CNT=10, REP_RATE_CNT=3, REP_EN=1)
REQ-025 Assert rst mid-clock-cycle -> o_press=000 and o_level=000 immediately.
REQ-026 i_btn[0] high for 30 cycles starting at edge 0 -> o_press[0] pulses at edges 7, 18, 22, 26, 30; o_level[0]=1 from edge 7.
REQ-027 i_btn[1] glitches high for 3 cycles -> o_press[1] and o_level[1] stay 0.
REQ-028 i_btn[0] and i_btn[2] rise on the same edge -> identical, simultaneous pulse trains on bits 0 and 2.
REQ-029 Release after hold at edge r -> o_level clears at edge r+7; a re-press during DEB_RELEASE -> no extra pulse, and repeats resume after 11 cycles.
REQ-030 REP_EN=0 with i_btn held for 40 cycles -> exactly one o_press pulse, at edge 7.
